// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel sequencer: FSM states, route_o bit map
// and the one-hot route codes built from it.
package pixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_INTEG = 3'd2,
    ST_SMP_A = 3'd3,
    ST_SMP_B = 3'd4,
    ST_CMP   = 3'd5,
    ST_DONE  = 3'd6
  } pix_state_e;

  localparam int ROUTE_W        = 5;
  localparam int ROUTE_OTA_OUT  = 0;
  localparam int ROUTE_SH_OUT   = 1;
  localparam int ROUTE_CMP_OUT  = 2;
  localparam int ROUTE_OTA_SH   = 3;
  localparam int ROUTE_VREF_CMP = 4;

  localparam logic [ROUTE_W-1:0] ROUTE_OH_OTA_OUT  = 5'b00001 << ROUTE_OTA_OUT;
  localparam logic [ROUTE_W-1:0] ROUTE_OH_SH_OUT   = 5'b00001 << ROUTE_SH_OUT;
  localparam logic [ROUTE_W-1:0] ROUTE_OH_CMP_OUT  = 5'b00001 << ROUTE_CMP_OUT;
  localparam logic [ROUTE_W-1:0] ROUTE_OH_OTA_SH   = 5'b00001 << ROUTE_OTA_SH;
  localparam logic [ROUTE_W-1:0] ROUTE_OH_VREF_CMP = 5'b00001 << ROUTE_VREF_CMP;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pd_next_sel.sv
// Finds the lowest enabled channel above (or, with incl_i, at or above)
// from_i. found_o is low when no such channel exists.
module pd_next_sel
  import pixel_pkg::*;
#(
  parameter int N_PD = 12,
  parameter int CH_W = ch_width(N_PD)
) (
  input  logic [N_PD-1:0] mask_i,
  input  logic [CH_W-1:0] from_i,
  input  logic            incl_i,
  output logic            found_o,
  output logic [CH_W-1:0] idx_o
);

  // Priority search: scanning downwards lets the lowest hit win.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N_PD - 1; i >= 0; i--) begin
      found_o = (mask_i[i] && ((CH_W'(i) > from_i) || (incl_i && (CH_W'(i) == from_i))))
                ? 1'b1 : found_o;
      idx_o   = (mask_i[i] && ((CH_W'(i) > from_i) || (incl_i && (CH_W'(i) == from_i))))
                ? CH_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Pixel readout sequencer: reset, integrate, then sample/compare each enabled
// photodiode channel in ascending order. All outputs come straight from flops;
// output flops are loaded from the decode of the *next* state so they line up
// with the state register.
module pixel_seq_ctrl
  import pixel_pkg::*;
#(
  parameter int N_PD = 12,
  parameter int TW   = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [N_PD-1:0]     pd_en_i,
  input  logic [TW-1:0]       t_rst_i,
  input  logic [TW-1:0]       t_int_i,
  input  logic [TW-1:0]       t_sh_i,
  input  logic [TW-1:0]       t_cmp_i,
  input  logic                vref_ext_i,
  input  logic                cmp_i,
  output logic                sh_rst_o,
  output logic                sw1_o,
  output logic                sw2_o,
  output logic                sh_o,
  output logic                sh_cmp_o,
  output logic [N_PD-1:0]     pd_a_o,
  output logic [N_PD-1:0]     pd_b_o,
  output logic [ROUTE_W-1:0]  route_o,
  output logic                vref_sel_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                bits_valid_o,
  output logic [N_PD-1:0]     bits_o
);

  localparam int CH_W = ch_width(N_PD);

  pix_state_e        state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [N_PD-1:0]   mask_q, mask_d;
  logic [TW-1:0]     t_rst_q, t_rst_d, t_int_q, t_int_d;
  logic [TW-1:0]     t_sh_q, t_sh_d, t_cmp_q, t_cmp_d;
  logic              vref_q, vref_d;
  logic [N_PD-1:0]   bits_q, bits_d;
  logic              bits_valid_q, bits_valid_d;

  logic              sh_rst_q, sh_rst_d, sw1_q, sw1_d, sw2_q, sw2_d;
  logic              sh_q, sh_d, sh_cmp_q, sh_cmp_d;
  logic [N_PD-1:0]   pd_a_q, pd_a_d, pd_b_q, pd_b_d;
  logic [ROUTE_W-1:0] route_q, route_d;
  logic              vref_sel_q, vref_sel_d, busy_q, busy_d, done_q, done_d;

  logic [CH_W-1:0]   srch_from_s;
  logic              srch_incl_s;
  logic              nxt_found_s;
  logic [CH_W-1:0]   nxt_idx_s;
  logic              phase_end_s;

  // Counter reload value: a phase of t cycles counts t-1 down to 0; t=0 acts as 1.
  function automatic logic [TW-1:0] phase_load(input logic [TW-1:0] t);
    return (t == '0) ? '0 : (t - TW'(1));
  endfunction

  assign phase_end_s = (cnt_q == '0);

  // From CMP search strictly above the current channel; from INTEG start at 0.
  always_comb begin
    if (state_q == ST_CMP) begin
      srch_from_s = ch_q;
      srch_incl_s = 1'b0;
    end else begin
      srch_from_s = '0;
      srch_incl_s = 1'b1;
    end
  end

  pd_next_sel #(
    .N_PD (N_PD),
    .CH_W (CH_W)
  ) u_next_sel (
    .mask_i  (mask_q),
    .from_i  (srch_from_s),
    .incl_i  (srch_incl_s),
    .found_o (nxt_found_s),
    .idx_o   (nxt_idx_s)
  );

  // Next-state, phase counter, channel pointer and frame configuration latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    mask_d       = mask_q;
    t_rst_d      = t_rst_q;
    t_int_d      = t_int_q;
    t_sh_d       = t_sh_q;
    t_cmp_d      = t_cmp_q;
    vref_d       = vref_q;
    bits_d       = bits_q;
    bits_valid_d = bits_valid_q;
    if (state_q == ST_IDLE) begin
      if (start_i) begin
        state_d      = ST_RST;
        cnt_d        = phase_load(t_rst_i);
        ch_d         = '0;
        mask_d       = pd_en_i;
        t_rst_d      = t_rst_i;
        t_int_d      = t_int_i;
        t_sh_d       = t_sh_i;
        t_cmp_d      = t_cmp_i;
        vref_d       = vref_ext_i;
        bits_d       = '0;
        bits_valid_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (abort_i) begin
      // Abort wins over any phase completion in the same cycle.
      state_d      = ST_IDLE;
      cnt_d        = '0;
      ch_d         = '0;
      bits_valid_d = 1'b0;
    end else if (!phase_end_s) begin
      cnt_d = cnt_q - TW'(1);
    end else begin
      case (state_q)
        ST_RST: begin
          state_d = ST_INTEG;
          cnt_d   = phase_load(t_int_q);
        end
        ST_INTEG, ST_CMP: begin
          if (state_q == ST_CMP) begin
            bits_d[ch_q] = cmp_i;
          end else begin
            bits_d = bits_q;
          end
          if (nxt_found_s) begin
            state_d = ST_SMP_A;
            ch_d    = nxt_idx_s;
            cnt_d   = phase_load(t_sh_q);
          end else begin
            state_d      = ST_DONE;
            cnt_d        = '0;
            bits_valid_d = 1'b1;
          end
        end
        ST_SMP_A: begin
          state_d = ST_SMP_B;
          cnt_d   = phase_load(t_sh_q);
        end
        ST_SMP_B: begin
          state_d = ST_CMP;
          cnt_d   = phase_load(t_cmp_q);
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ch_d    = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ch_d    = '0;
        end
      endcase
    end
  end

  // Output decode of the upcoming state, so the output flops track state_q.
  always_comb begin
    sh_rst_d = 1'b0;
    sw1_d    = 1'b0;
    sw2_d    = 1'b0;
    sh_d     = 1'b0;
    sh_cmp_d = 1'b0;
    pd_a_d   = '0;
    pd_b_d   = '0;
    done_d   = 1'b0;
    route_d  = ROUTE_OH_OTA_OUT;
    case (state_d)
      ST_IDLE:  route_d = ROUTE_OH_OTA_OUT;
      ST_RST: begin
        sh_rst_d = 1'b1;
        route_d  = ROUTE_OH_OTA_SH;
      end
      ST_INTEG: route_d = ROUTE_OH_OTA_SH;
      ST_SMP_A: begin
        pd_a_d[ch_d] = 1'b1;
        sw1_d        = 1'b1;
        sh_d         = 1'b1;
        route_d      = ROUTE_OH_SH_OUT;
      end
      ST_SMP_B: begin
        pd_b_d[ch_d] = 1'b1;
        sw2_d        = 1'b1;
        sh_d         = 1'b1;
        route_d      = ROUTE_OH_SH_OUT;
      end
      ST_CMP: begin
        sh_cmp_d = 1'b1;
        route_d  = vref_d ? ROUTE_OH_VREF_CMP : ROUTE_OH_CMP_OUT;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        route_d = ROUTE_OH_OTA_OUT;
      end
      default:  route_d = ROUTE_OH_OTA_OUT;
    endcase
    busy_d     = (state_d != ST_IDLE);
    vref_sel_d = (state_d != ST_IDLE) ? vref_d : 1'b0;
  end

  // Sequencer state, counter and latched frame configuration.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      mask_q       <= '0;
      t_rst_q      <= '0;
      t_int_q      <= '0;
      t_sh_q       <= '0;
      t_cmp_q      <= '0;
      vref_q       <= 1'b0;
      bits_q       <= '0;
      bits_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      mask_q       <= mask_d;
      t_rst_q      <= t_rst_d;
      t_int_q      <= t_int_d;
      t_sh_q       <= t_sh_d;
      t_cmp_q      <= t_cmp_d;
      vref_q       <= vref_d;
      bits_q       <= bits_d;
      bits_valid_q <= bits_valid_d;
    end
  end

  // Registered switch controls, route select and status.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sh_rst_q   <= 1'b0;
      sw1_q      <= 1'b0;
      sw2_q      <= 1'b0;
      sh_q       <= 1'b0;
      sh_cmp_q   <= 1'b0;
      pd_a_q     <= '0;
      pd_b_q     <= '0;
      route_q    <= ROUTE_OH_OTA_OUT;
      vref_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sh_rst_q   <= sh_rst_d;
      sw1_q      <= sw1_d;
      sw2_q      <= sw2_d;
      sh_q       <= sh_d;
      sh_cmp_q   <= sh_cmp_d;
      pd_a_q     <= pd_a_d;
      pd_b_q     <= pd_b_d;
      route_q    <= route_d;
      vref_sel_q <= vref_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sh_rst_o     = sh_rst_q;
  assign sw1_o        = sw1_q;
  assign sw2_o        = sw2_q;
  assign sh_o         = sh_q;
  assign sh_cmp_o     = sh_cmp_q;
  assign pd_a_o       = pd_a_q;
  assign pd_b_o       = pd_b_q;
  assign route_o      = route_q;
  assign vref_sel_o   = vref_sel_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign bits_valid_o = bits_valid_q;
  assign bits_o       = bits_q;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Self-checking bench for pixel_seq_ctrl (N_PD=4). A schedule model lists the
// phase of every cycle of a frame; expected outputs are derived per phase.
module tb_pixel_seq_ctrl;

  localparam int NPD = 4;
  localparam int TWB = 8;
  localparam int P_IDLE = 0, P_RST = 1, P_INTEG = 2, P_SMPA = 3, P_SMPB = 4, P_CMP = 5, P_DONE = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0, vref_ext_i = 1'b0, cmp_i = 1'b0;
  logic [NPD-1:0] pd_en_i = '0;
  logic [TWB-1:0] t_rst_i = '0, t_int_i = '0, t_sh_i = '0, t_cmp_i = '0;
  logic sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, vref_sel_o, busy_o, done_o, bits_valid_o;
  logic [NPD-1:0] pd_a_o, pd_b_o, bits_o;
  logic [4:0] route_o;

  int errors = 0;
  int checks = 0;

  typedef struct { int ph; int ch; bit last; } step_t;
  step_t sched[$];
  logic [21:0] obs_q[$];
  logic [21:0] obs_post;
  logic [NPD-1:0] bits_post;

  always #5 clk = ~clk;

  pixel_seq_ctrl #(.N_PD(NPD), .TW(TWB)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .pd_en_i(pd_en_i), .t_rst_i(t_rst_i), .t_int_i(t_int_i), .t_sh_i(t_sh_i),
    .t_cmp_i(t_cmp_i), .vref_ext_i(vref_ext_i), .cmp_i(cmp_i),
    .sh_rst_o(sh_rst_o), .sw1_o(sw1_o), .sw2_o(sw2_o), .sh_o(sh_o), .sh_cmp_o(sh_cmp_o),
    .pd_a_o(pd_a_o), .pd_b_o(pd_b_o), .route_o(route_o), .vref_sel_o(vref_sel_o),
    .busy_o(busy_o), .done_o(done_o), .bits_valid_o(bits_valid_o), .bits_o(bits_o)
  );

  function automatic int tm(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  function automatic int frame_len(input logic [NPD-1:0] m, input int a, input int b, input int c, input int d);
    return tm(a) + tm(b) + $countones(m) * (2 * tm(c) + tm(d)) + 1;
  endfunction

  // Phase-per-cycle schedule of one frame.
  task automatic build_sched(input logic [NPD-1:0] m, input int a, input int b, input int c, input int d);
    sched.delete();
    for (int j = 0; j < tm(a); j++) sched.push_back('{ph: P_RST, ch: 0, last: 1'b0});
    for (int j = 0; j < tm(b); j++) sched.push_back('{ph: P_INTEG, ch: 0, last: 1'b0});
    for (int ch = 0; ch < NPD; ch++) begin
      if (m[ch]) begin
        for (int j = 0; j < tm(c); j++) sched.push_back('{ph: P_SMPA, ch: ch, last: 1'b0});
        for (int j = 0; j < tm(c); j++) sched.push_back('{ph: P_SMPB, ch: ch, last: 1'b0});
        for (int j = 0; j < tm(d); j++) sched.push_back('{ph: P_CMP, ch: ch, last: (j == tm(d) - 1)});
      end
    end
    sched.push_back('{ph: P_DONE, ch: 0, last: 1'b0});
  endtask

  // {sh_rst,sw1,sw2,sh,sh_cmp, pd_a, pd_b, route, vref_sel, busy, done, bits_valid}
  function automatic logic [21:0] exp_vec(input int ph, input int ch, input logic vref, input logic bv);
    logic [4:0] sw;
    logic [3:0] pa, pb;
    logic [4:0] rt;
    logic vs, bz, dn;
    sw = 5'b00000; pa = 4'b0000; pb = 4'b0000; rt = 5'b00001;
    bz = (ph != P_IDLE);
    dn = (ph == P_DONE);
    vs = bz ? vref : 1'b0;
    case (ph)
      P_RST:   begin sw = 5'b10000; rt = 5'b01000; end
      P_INTEG: rt = 5'b01000;
      P_SMPA:  begin sw = 5'b01010; pa = 4'b0001 << ch; rt = 5'b00010; end
      P_SMPB:  begin sw = 5'b00110; pb = 4'b0001 << ch; rt = 5'b00010; end
      P_CMP:   begin sw = 5'b00001; rt = vref ? 5'b10000 : 5'b00100; end
      default: rt = 5'b00001;
    endcase
    return {sw, pa, pb, rt, vs, bz, dn, bv};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, pd_a_o, pd_b_o, route_o,
            vref_sel_o, busy_o, done_o, bits_valid_o};
  endfunction

  function automatic int first_done();
    for (int k = 0; k < obs_q.size(); k++) if (obs_q[k][1]) return k;
    return -1;
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (obs_q[k]) if (obs_q[k][1]) n++;
    return n;
  endfunction

  // Drive one frame and record outputs each cycle; stop_at >= 0 aborts
  // (or, with use_rst, asserts reset mid-cycle) in that schedule cycle.
  task automatic run_frame(input logic [NPD-1:0] m, input int a, input int b, input int c, input int d,
                           input logic vref, input logic [NPD-1:0] pat, input bit noise,
                           input bit disturb, input int stop_at, input bit use_rst);
    bit stopped = 1'b0;
    build_sched(m, a, b, c, d);
    obs_q.delete();
    @(negedge clk);
    pd_en_i = m; t_rst_i = TWB'(a); t_int_i = TWB'(b); t_sh_i = TWB'(c); t_cmp_i = TWB'(d);
    vref_ext_i = vref; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < sched.size(); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      obs_q.push_back(dut_vec());
      if (sched[k].ph == P_CMP && (sched[k].last || !noise)) cmp_i = pat[sched[k].ch];
      else if (noise) cmp_i = 1'($urandom_range(1, 0));
      else cmp_i = 1'b0;
      if (disturb) begin
        start_i = (k < sched.size() - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
        pd_en_i = NPD'($urandom); t_rst_i = TWB'($urandom); t_int_i = TWB'($urandom);
        t_sh_i = TWB'($urandom); t_cmp_i = TWB'($urandom); vref_ext_i = 1'($urandom);
      end
      if (k == stop_at) begin
        if (use_rst) begin
          #2 rst_n = 1'b0;
          #1 obs_post = dut_vec(); bits_post = bits_o;
          @(negedge clk); rst_n = 1'b1;
        end else begin
          abort_i = 1'b1;
          @(posedge clk); #1;
          obs_post = dut_vec(); bits_post = bits_o;
          abort_i = 1'b0;
        end
        stopped = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    if (!stopped) begin
      @(posedge clk); #1;
      obs_post = dut_vec(); bits_post = bits_o;
    end
    cmp_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== exp_vec(P_IDLE, 0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_outputs got %b want %b", dut_vec(), exp_vec(P_IDLE, 0, 1'b0, 1'b0));
    end
    checks++;
    if (bits_o !== 4'b0000) begin errors++; $display("FAIL reset_bits got %b want 0000", bits_o); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_full_mask();
    run_frame(4'b1111, 2, 3, 1, 2, 1'b0, 4'b1010, 1'b0, 1'b0, -1, 1'b0);
    for (int k = 0; k < sched.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE)) begin
        errors++; $display("FAIL full_cyc%0d got %b want %b", k + 1, obs_q[k], exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE));
      end
    end
    checks++;
    if (first_done() + 1 !== 22) begin errors++; $display("FAIL full_done_cycle got %0d want 22", first_done() + 1); end
    checks++;
    if (bits_post !== 4'b1010) begin errors++; $display("FAIL full_bits got %b want 1010", bits_post); end
    checks++;
    if (obs_post !== exp_vec(P_IDLE, 0, 1'b0, 1'b1)) begin errors++; $display("FAIL full_post got %b want %b", obs_post, exp_vec(P_IDLE, 0, 1'b0, 1'b1)); end
  endtask

  task automatic test_sparse_mask();
    run_frame(4'b0101, 2, 3, 1, 2, 1'b0, 4'b1010, 1'b0, 1'b0, -1, 1'b0);
    for (int k = 0; k < sched.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE)) begin
        errors++; $display("FAIL sparse_cyc%0d got %b want %b", k + 1, obs_q[k], exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE));
      end
    end
    checks++;
    if (first_done() + 1 !== 14) begin errors++; $display("FAIL sparse_len got %0d want 14", first_done() + 1); end
    checks++;
    if (bits_post !== 4'b0000) begin errors++; $display("FAIL sparse_bits got %b want 0000", bits_post); end
  endtask

  task automatic test_zero_mask();
    run_frame(4'b0000, 0, 0, 1, 2, 1'b0, 4'b1111, 1'b0, 1'b0, -1, 1'b0);
    for (int k = 0; k < sched.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE)) begin
        errors++; $display("FAIL zero_cyc%0d got %b want %b", k + 1, obs_q[k], exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE));
      end
    end
    checks++;
    if (first_done() + 1 !== 3) begin errors++; $display("FAIL zero_done_cycle got %0d want 3", first_done() + 1); end
    checks++;
    if (bits_post !== 4'b0000) begin errors++; $display("FAIL zero_bits got %b want 0000", bits_post); end
  endtask

  task automatic test_abort();
    // First SMP_B cycle of channel 2: RST 2 + INTEG 3 + two channels of 4 + SMP_A 1.
    int stop = 2 + 3 + 2 * (2 * 1 + 2) + 1;
    run_frame(4'b1111, 2, 3, 1, 2, 1'b0, 4'b1111, 1'b0, 1'b0, stop, 1'b0);
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_vec(sched[k].ph, sched[k].ch, 1'b0, 1'b0)) begin
        errors++; $display("FAIL abort_cyc%0d got %b want %b", k + 1, obs_q[k], exp_vec(sched[k].ph, sched[k].ch, 1'b0, 1'b0));
      end
    end
    checks++;
    if (obs_post !== exp_vec(P_IDLE, 0, 1'b0, 1'b0)) begin errors++; $display("FAIL abort_post got %b want %b", obs_post, exp_vec(P_IDLE, 0, 1'b0, 1'b0)); end
    checks++;
    if (count_done() !== 0) begin errors++; $display("FAIL abort_done_count got %0d want 0", count_done()); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      logic [NPD-1:0] m = NPD'($urandom);
      logic [NPD-1:0] pat = NPD'($urandom);
      logic vr = 1'($urandom);
      int a = $urandom_range(3, 0), b = $urandom_range(3, 0), c = $urandom_range(3, 0), d = $urandom_range(3, 0);
      run_frame(m, a, b, c, d, vr, pat, 1'b1, 1'b0, -1, 1'b0);
      for (int k = 0; k < sched.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_vec(sched[k].ph, sched[k].ch, vr, sched[k].ph == P_DONE)) begin
          errors++; $display("FAIL rand%0d_cyc%0d got %b want %b", f, k + 1, obs_q[k], exp_vec(sched[k].ph, sched[k].ch, vr, sched[k].ph == P_DONE));
        end
      end
      checks++;
      if (first_done() + 1 !== frame_len(m, a, b, c, d)) begin
        errors++; $display("FAIL rand%0d_len got %0d want %0d", f, first_done() + 1, frame_len(m, a, b, c, d));
      end
      checks++;
      if (bits_post !== (pat & m)) begin errors++; $display("FAIL rand%0d_bits got %b want %b", f, bits_post, pat & m); end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      logic [NPD-1:0] m = (f == 0) ? 4'b1011 : 4'b0110;
      logic [NPD-1:0] pat = NPD'($urandom);
      run_frame(m, 1, 2, 2, 1, 1'b0, pat, 1'b1, 1'b1, -1, 1'b0);
      for (int k = 0; k < sched.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE)) begin
          errors++; $display("FAIL b2b%0d_cyc%0d got %b want %b", f, k + 1, obs_q[k], exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE));
        end
      end
      checks++;
      if (count_done() !== 1) begin errors++; $display("FAIL b2b%0d_done_count got %0d want 1", f, count_done()); end
      checks++;
      if (first_done() + 1 !== frame_len(m, 1, 2, 2, 1)) begin
        errors++; $display("FAIL b2b%0d_len got %0d want %0d", f, first_done() + 1, frame_len(m, 1, 2, 2, 1));
      end
      checks++;
      if (obs_post !== exp_vec(P_IDLE, 0, 1'b0, 1'b1)) begin errors++; $display("FAIL b2b%0d_post got %b want %b", f, obs_post, exp_vec(P_IDLE, 0, 1'b0, 1'b1)); end
    end
  endtask

  task automatic test_vref_reset();
    // First CMP cycle: RST 2 + INTEG 3 + SMP_A 1 + SMP_B 1.
    int stop = 2 + 3 + 1 + 1;
    run_frame(4'b1111, 2, 3, 1, 2, 1'b1, 4'b1111, 1'b0, 1'b0, stop, 1'b1);
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_vec(sched[k].ph, sched[k].ch, 1'b1, 1'b0)) begin
        errors++; $display("FAIL vref_cyc%0d got %b want %b", k + 1, obs_q[k], exp_vec(sched[k].ph, sched[k].ch, 1'b1, 1'b0));
      end
    end
    checks++;
    if (obs_q[stop][8:4] !== 5'b10000 || obs_q[stop][3] !== 1'b1) begin
      errors++; $display("FAIL vref_cmp_route got route=%b vref_sel=%b want 10000/1", obs_q[stop][8:4], obs_q[stop][3]);
    end
    checks++;
    if (obs_post !== exp_vec(P_IDLE, 0, 1'b0, 1'b0)) begin errors++; $display("FAIL async_rst got %b want %b", obs_post, exp_vec(P_IDLE, 0, 1'b0, 1'b0)); end
    checks++;
    if (bits_post !== 4'b0000) begin errors++; $display("FAIL async_rst_bits got %b want 0000", bits_post); end
  endtask

  task automatic test_recovery();
    run_frame(4'b1000, 1, 1, 1, 1, 1'b0, 4'b1000, 1'b0, 1'b0, -1, 1'b0);
    for (int k = 0; k < sched.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE)) begin
        errors++; $display("FAIL recov_cyc%0d got %b want %b", k + 1, obs_q[k], exp_vec(sched[k].ph, sched[k].ch, 1'b0, sched[k].ph == P_DONE));
      end
    end
    checks++;
    if (bits_post !== 4'b1000) begin errors++; $display("FAIL recov_bits got %b want 1000", bits_post); end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_zero_mask();
    test_abort();
    test_random();
    test_back_to_back();
    test_vref_reset();
    test_recovery();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
